// File: rtl/clk_gen_multi_if.sv
// Control/status bundle for clk_gen_multi: divisor loads, run/step requests
// from the controller side, divided clocks, edge enables and status back.
interface clk_gen_multi_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8
);
    logic [CHANNELS*CNT_W-1:0] div_half;
    logic [CHANNELS-1:0]       div_load;
    logic [CHANNELS-1:0]       run;
    logic [CHANNELS-1:0]       step;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       rise_en;
    logic [CHANNELS-1:0]       fall_en;
    logic [CHANNELS-1:0]       busy;
    logic                      ready;

    modport master (
        output div_half, div_load, run, step,
        input  clk_out, rise_en, fall_en, busy, ready
    );

    modport slave (
        input  div_half, div_load, run, step,
        output clk_out, rise_en, fall_en, busy, ready
    );
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel 50% duty clock divider with glitch-free start/stop, debug
// single-step, runtime divisor reload and a post-reset startup hold-off.
module clk_gen_multi #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 8,
    parameter int START_DLY    = 1,
    parameter int DEFAULT_HALF = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_gen_multi_if.slave bus
);

    localparam int DLY_W = (START_DLY < 1) ? 1 : $clog2(START_DLY + 1);

    typedef enum logic {
        ST_WAIT,
        ST_READY
    } startup_state_t;

    startup_state_t     st_q, st_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic               ready_int;

    logic [CHANNELS-1:0] clk_vec;
    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] fall_vec;
    logic [CHANNELS-1:0] busy_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_WAIT;
            dly_q <= '0;
        end else begin
            st_q  <= st_d;
            dly_q <= dly_d;
        end
    end

    // ready must appear on exactly the START_DLY-th edge after reset release
    always_comb begin
        st_d  = st_q;
        dly_d = dly_q;
        case (st_q)
            ST_WAIT: begin
                if (dly_q == DLY_W'(START_DLY - 1)) begin
                    st_d = ST_READY;
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
            ST_READY: begin
                st_d = ST_READY;
            end
            default: begin
                st_d  = ST_WAIT;
                dly_d = '0;
            end
        endcase
    end

    always_comb begin
        ready_int = (st_q == ST_READY);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] half_q;
        logic [CNT_W-1:0] pend_q;
        logic             pend_v_q;
        logic             clk_q;
        logic             rise_q;
        logic             fall_q;
        logic             busy_q;
        logic [CNT_W-1:0] div_in;
        logic             active;
        logic             at_top;
        logic             period_end;
        logic             idle;
        logic             step_ok;

        assign div_in     = bus.div_half[g*CNT_W +: CNT_W];
        assign active     = ready_int & (bus.run[g] | busy_q | clk_q | (cnt_q != '0));
        assign at_top     = (cnt_q == half_q);
        assign period_end = active & at_top & clk_q;
        assign idle       = ~active & ~clk_q & (cnt_q == '0);
        assign step_ok    = bus.step[g] & ~bus.run[g] & ~busy_q & idle;

        // Edge enables are registered with the toggle so they line up with clk_out
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (active) begin
                    if (at_top) begin
                        cnt_q  <= '0;
                        clk_q  <= ~clk_q;
                        rise_q <= ~clk_q;
                        fall_q <= clk_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end

        // A new divisor only takes effect between periods; a load on the
        // swap edge wins and waits for the following boundary
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                half_q   <= CNT_W'(DEFAULT_HALF);
                pend_q   <= '0;
                pend_v_q <= 1'b0;
            end else begin
                if ((period_end || idle) && pend_v_q) begin
                    half_q   <= pend_q;
                    pend_v_q <= 1'b0;
                end
                if (bus.div_load[g]) begin
                    pend_q   <= div_in;
                    pend_v_q <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_q <= 1'b0;
            end else if (step_ok) begin
                busy_q <= 1'b1;
            end else if (period_end) begin
                busy_q <= 1'b0;
            end
        end

        assign clk_vec[g]  = clk_q;
        assign rise_vec[g] = rise_q;
        assign fall_vec[g] = fall_q;
        assign busy_vec[g] = busy_q;
    end

    assign bus.clk_out = clk_vec;
    assign bus.rise_en = rise_vec;
    assign bus.fall_en = fall_vec;
    assign bus.busy    = busy_vec;
    assign bus.ready   = ready_int;

endmodule
